// File: rtl/led_pwm_avmm_slave.sv
// Avalon-MM responder for the HPS lightweight bridge that drives a bank of LEDs
// with a global PWM dimmer and an optional blink gate.
//
// Optional feature macro: LED_PWM_BYTEENABLE_EN
//   defined   -> avs_byteenable[3:0] is present and gates each register byte lane on writes
//   undefined -> no byteenable port; every write updates the full word
//
// Ports:
//   clk_clk            system clock
//   reset_reset_n      asynchronous active-low reset
//   avs_address        word address (0 CTRL, 1 LED_VALUE, 2 DUTY, 3 PERIOD, 4 STATUS, 5..7 reserved)
//   avs_read/avs_write single-cycle transfer requests, no waitrequest
//   avs_writedata      write data
//   avs_byteenable     byte lane enables (LED_PWM_BYTEENABLE_EN builds only)
//   avs_readdata       read data, registered, valid with avs_readdatavalid
//   avs_readdatavalid  one-cycle strobe, one cycle after each read request
//   led_out            LED drive, active high, registered
module led_pwm_avmm_slave #(
  parameter int unsigned LED_WIDTH  = 32,
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned BLINK_BITS = 24
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  input  logic [2:0]           avs_address,
  input  logic                 avs_read,
  input  logic                 avs_write,
  input  logic [31:0]          avs_writedata,
`ifdef LED_PWM_BYTEENABLE_EN
  input  logic [3:0]           avs_byteenable,
`endif
  output logic [31:0]          avs_readdata,
  output logic                 avs_readdatavalid,
  output logic [LED_WIDTH-1:0] led_out
);

  localparam int unsigned DW = 32;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_LED    = 3'd1;
  localparam logic [2:0] ADDR_DUTY   = 3'd2;
  localparam logic [2:0] ADDR_PERIOD = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;

  logic                  enable_q;
  logic                  blink_en_q;
  logic [LED_WIDTH-1:0]  led_value_q;
  logic [PWM_BITS-1:0]   duty_q;
  logic [BLINK_BITS-1:0] period_q;
  logic [PWM_BITS-1:0]   pwm_cnt_q;
  logic [BLINK_BITS-1:0] blink_cnt_q;
  logic                  blink_phase_q;

  logic [DW-1:0] wr_mask_c;
  logic [DW-1:0] ctrl_rd_c;
  logic [DW-1:0] led_rd_c;
  logic [DW-1:0] duty_rd_c;
  logic [DW-1:0] period_rd_c;
  logic [DW-1:0] status_rd_c;
  logic [DW-1:0] rd_mux_c;
  logic          wr_ctrl_c;
  logic          wr_led_c;
  logic          wr_duty_c;
  logic          wr_period_c;
  logic          pwm_on_c;
  logic          phase_eff_c;

  // Byte-lane write mask
`ifdef LED_PWM_BYTEENABLE_EN
  assign wr_mask_c = {{8{avs_byteenable[3]}}, {8{avs_byteenable[2]}},
                      {8{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};
`else
  assign wr_mask_c = '1;
`endif

  // Replace only the enabled lanes of a zero-extended register image
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                          input logic [DW-1:0] new_v,
                                          input logic [DW-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // Zero-extended register images, shared by the read mux and write merge
  always_comb begin
    ctrl_rd_c   = '0;
    led_rd_c    = '0;
    duty_rd_c   = '0;
    period_rd_c = '0;
    status_rd_c = '0;
    ctrl_rd_c[1:0]                = {blink_en_q, enable_q};
    led_rd_c[LED_WIDTH-1:0]       = led_value_q;
    duty_rd_c[PWM_BITS-1:0]       = duty_q;
    period_rd_c[BLINK_BITS-1:0]   = period_q;
    status_rd_c[8 +: PWM_BITS]    = pwm_cnt_q;
    status_rd_c[0]                = blink_phase_q;
  end

  // Read mux; reserved addresses return 0
  always_comb begin
    rd_mux_c = '0;
    case (avs_address)
      ADDR_CTRL:   rd_mux_c = ctrl_rd_c;
      ADDR_LED:    rd_mux_c = led_rd_c;
      ADDR_DUTY:   rd_mux_c = duty_rd_c;
      ADDR_PERIOD: rd_mux_c = period_rd_c;
      ADDR_STATUS: rd_mux_c = status_rd_c;
      default:     rd_mux_c = '0;
    endcase
  end

  assign wr_ctrl_c   = avs_write && (avs_address == ADDR_CTRL);
  assign wr_led_c    = avs_write && (avs_address == ADDR_LED);
  assign wr_duty_c   = avs_write && (avs_address == ADDR_DUTY);
  assign wr_period_c = avs_write && (avs_address == ADDR_PERIOD);

  // Read response: sampled from pre-write state, so a colliding write is not visible
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= avs_read;
      if (avs_read) begin
        avs_readdata <= rd_mux_c;
      end
    end
  end

  // Control registers
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      enable_q    <= 1'b0;
      blink_en_q  <= 1'b0;
      led_value_q <= '0;
      duty_q      <= '0;
    end else begin
      if (wr_ctrl_c) begin
        {blink_en_q, enable_q} <= 2'(merge(ctrl_rd_c, avs_writedata, wr_mask_c));
      end
      if (wr_led_c) begin
        led_value_q <= LED_WIDTH'(merge(led_rd_c, avs_writedata, wr_mask_c));
      end
      if (wr_duty_c) begin
        duty_q <= PWM_BITS'(merge(duty_rd_c, avs_writedata, wr_mask_c));
      end
    end
  end

  // PWM counter: free-runs while enabled, parked at 0 otherwise
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pwm_cnt_q <= '0;
    end else if (enable_q) begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
    end else begin
      pwm_cnt_q <= '0;
    end
  end

  // Blink period register and phase generator; a PERIOD write restarts the phase
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      period_q      <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (wr_period_c) begin
      period_q      <= BLINK_BITS'(merge(period_rd_c, avs_writedata, wr_mask_c));
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else if (!enable_q) begin
      blink_cnt_q <= '0;
    end else if (!blink_en_q || (period_q == '0)) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else if (blink_cnt_q == period_q - BLINK_BITS'(1)) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + BLINK_BITS'(1);
    end
  end

  // Gate terms; blinking disabled or PERIOD=0 forces the phase on without waiting a cycle
  assign pwm_on_c    = (duty_q == '1) || (pwm_cnt_q < duty_q);
  assign phase_eff_c = blink_phase_q || !blink_en_q || (period_q == '0);

  // LED drive, one cycle behind the state
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      led_out <= '0;
    end else if (enable_q) begin
      led_out <= led_value_q & {LED_WIDTH{pwm_on_c & phase_eff_c}};
    end else begin
      led_out <= '0;
    end
  end

endmodule

// File: tb/tb_led_pwm_avmm_slave.sv
// Self-checking bench for led_pwm_avmm_slave (default parameters).
// A cycle-level behavioural model predicts led_out / read responses and is compared on
// every falling edge; directed sequences add literal expectations.
module tb_led_pwm_avmm_slave;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b1;
  logic [2:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
`ifdef LED_PWM_BYTEENABLE_EN
  logic [3:0]  avs_byteenable = 4'hF;
`endif
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic [31:0] led_out;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  led_pwm_avmm_slave dut (
    .clk_clk           (clk_clk),
    .reset_reset_n     (reset_reset_n),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
`ifdef LED_PWM_BYTEENABLE_EN
    .avs_byteenable    (avs_byteenable),
`endif
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .led_out           (led_out)
  );

  always #5 clk_clk = ~clk_clk;

  // ---------------- behavioural model ----------------
  bit          m_en = 0, m_ben = 0, m_phase = 0;
  int unsigned m_pwm = 0, m_duty = 0, m_period = 0, m_bcnt = 0;
  logic [31:0] m_ledval = '0, m_led = '0, m_rdata = '0;
  bit          m_rvalid = 0;

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return {30'd0, m_ben, m_en};
      3'd1:    return m_ledval;
      3'd2:    return 32'(m_duty);
      3'd3:    return 32'(m_period);
      3'd4:    return (32'(m_pwm) << 8) | 32'(m_phase);
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] mask;
    logic [31:0] nv;
    bit on;
    // outputs from the state before this edge
    on = (m_duty == 255 || m_pwm < m_duty) && (m_phase || !m_ben || m_period == 0);
    m_led = (m_en && on) ? m_ledval : 32'd0;
    m_rvalid = avs_read;
    if (avs_read) m_rdata = model_read(avs_address);
    // counters
    if (!m_en) begin
      m_pwm = 0;
      m_bcnt = 0;
    end else begin
      m_pwm = (m_pwm + 1) % 256;
      if (!m_ben || m_period == 0) begin
        m_bcnt = 0;
        m_phase = 1;
      end else if (m_bcnt + 1 == m_period) begin
        m_bcnt = 0;
        m_phase = !m_phase;
      end else begin
        m_bcnt = m_bcnt + 1;
      end
    end
    // register write, lane-masked
`ifdef LED_PWM_BYTEENABLE_EN
    mask = {{8{avs_byteenable[3]}}, {8{avs_byteenable[2]}}, {8{avs_byteenable[1]}}, {8{avs_byteenable[0]}}};
`else
    mask = 32'hFFFF_FFFF;
`endif
    if (avs_write && avs_address <= 3'd3) begin
      nv = (model_read(avs_address) & ~mask) | (avs_writedata & mask);
      case (avs_address)
        3'd0: begin m_en = nv[0]; m_ben = nv[1]; end
        3'd1: m_ledval = nv;
        3'd2: m_duty = int'(nv & 32'hFF);
        default: begin
          m_period = int'(nv & 32'hFF_FFFF);
          m_bcnt = 0;
          m_phase = 1;
        end
      endcase
    end
  endtask

  initial begin
    forever begin
      @(posedge clk_clk or negedge reset_reset_n);
      if (!reset_reset_n) begin
        m_en = 0; m_ben = 0; m_phase = 0;
        m_pwm = 0; m_duty = 0; m_period = 0; m_bcnt = 0;
        m_ledval = '0; m_led = '0; m_rdata = '0; m_rvalid = 0;
      end else begin
        model_step();
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk_clk);
      if (cmp_en) begin
        check("model_led_out", led_out, m_led);
        check("model_rvalid", 32'(avs_readdatavalid), 32'(m_rvalid));
        check("model_rdata", avs_readdata, m_rdata);
      end
    end
  end

  // ---------------- bus tasks ----------------
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
    @(negedge clk_clk);
    avs_address = a;
    avs_writedata = d;
    avs_write = 1'b1;
`ifdef LED_PWM_BYTEENABLE_EN
    avs_byteenable = be;
`else
    if (be != 4'hF) $display("note: byteenable ignored in this build");
`endif
    @(negedge clk_clk);
    avs_write = 1'b0;
`ifdef LED_PWM_BYTEENABLE_EN
    avs_byteenable = 4'hF;
`endif
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output logic v);
    @(negedge clk_clk);
    avs_address = a;
    avs_read = 1'b1;
    @(negedge clk_clk);
    avs_read = 1'b0;
    d = avs_readdata;
    v = avs_readdatavalid;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] d;
    logic        v;
    int          on_cnt, off_cnt, changes, last_chg, waited;
    logic        prev;

    #1 reset_reset_n = 1'b0;
    repeat (3) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    cmp_en = 1'b1;

    // Reset state: every address reads 0
    check("reset_led_out", led_out, 32'h0);
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), d, v);
      check("reset_read_valid", 32'(v), 32'd1);
      check("reset_read_data", d, 32'h0);
    end

    // Full-on PWM
    bus_write(3'd0, 32'h1);
    bus_write(3'd1, 32'h0000_00F0);
    bus_write(3'd2, 32'hFF);
    repeat (2) @(negedge clk_clk);
    on_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (led_out == 32'hF0) on_cnt++;
      @(negedge clk_clk);
    end
    check("duty_ff_steady", 32'(on_cnt), 32'd16);

    // Quarter duty: 64 of 256 cycles on
    bus_write(3'd2, 32'h40);
    repeat (2) @(negedge clk_clk);
    on_cnt = 0;
    off_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      if (led_out == 32'hF0) on_cnt++;
      else if (led_out == 32'h0) off_cnt++;
      @(negedge clk_clk);
    end
    check("duty_40_on_cycles", 32'(on_cnt), 32'd64);
    check("duty_40_off_cycles", 32'(off_cnt), 32'd192);

    // Blink with PERIOD=10: led toggles every 10 cycles
    bus_write(3'd0, 32'h3);
    bus_write(3'd3, 32'd10);
    bus_write(3'd2, 32'hFF);
    bus_write(3'd1, 32'h1);
    repeat (2) @(negedge clk_clk);
    prev = led_out[0];
    changes = 0;
    last_chg = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk_clk);
      if (led_out[0] != prev) begin
        if (last_chg >= 0) check("blink_half_period", 32'(i - last_chg), 32'd10);
        last_chg = i;
        changes++;
        prev = led_out[0];
      end
    end
    check("blink_toggle_count_ge7", 32'(changes >= 7), 32'd1);

    // PERIOD=0 stops blinking, LED steady on
    bus_write(3'd3, 32'd0);
    repeat (2) @(negedge clk_clk);
    on_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (led_out == 32'h1) on_cnt++;
      @(negedge clk_clk);
    end
    check("period0_steady_on", 32'(on_cnt), 32'd20);

    // Reserved address ignores writes
    bus_write(3'd6, 32'h1234_5678);
    bus_read(3'd6, d, v);
    check("reserved_read", d, 32'h0);

    // Three back-to-back reads
    bus_write(3'd1, 32'hA5);
    @(negedge clk_clk);
    avs_address = 3'd1;
    avs_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_clk);
      if (i == 2) avs_read = 1'b0;
      check("b2b_valid", 32'(avs_readdatavalid), 32'd1);
      check("b2b_data", avs_readdata, 32'hA5);
    end
    @(negedge clk_clk);
    check("b2b_valid_drop", 32'(avs_readdatavalid), 32'd0);
    check("b2b_data_hold", avs_readdata, 32'hA5);

    // Read and write together: read returns the old DUTY
    @(negedge clk_clk);
    avs_address = 3'd2;
    avs_writedata = 32'h33;
    avs_read = 1'b1;
    avs_write = 1'b1;
    @(negedge clk_clk);
    avs_read = 1'b0;
    avs_write = 1'b0;
    check("collide_old_data", avs_readdata, 32'hFF);
    bus_read(3'd2, d, v);
    check("collide_new_data", d, 32'h33);

`ifdef LED_PWM_BYTEENABLE_EN
    bus_write(3'd1, 32'hFFFF_FFFF, 4'hF);
    bus_write(3'd1, 32'h0, 4'b0101);
    bus_read(3'd1, d, v);
    check("byteenable_merge", d, 32'hFF00_FF00);
    bus_write(3'd1, 32'h1);
`endif

    // Asynchronous reset mid-blink with a read response in flight
    bus_write(3'd2, 32'hFF);
    bus_write(3'd3, 32'd10);
    waited = 0;
    while (led_out == 32'h0 && waited < 40) begin
      @(negedge clk_clk);
      waited++;
    end
    check("led_active_before_reset", 32'(led_out != 32'h0), 32'd1);
    @(negedge clk_clk);
    avs_address = 3'd1;
    avs_read = 1'b1;
    @(posedge clk_clk);
    #2;
    avs_read = 1'b0;
    check("inflight_valid", 32'(avs_readdatavalid), 32'd1);
    reset_reset_n = 1'b0;
    #1;
    check("async_reset_led", led_out, 32'h0);
    check("async_reset_valid", 32'(avs_readdatavalid), 32'd0);
    repeat (2) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    repeat (4) @(negedge clk_clk);
    check("post_reset_no_valid", 32'(avs_readdatavalid), 32'd0);
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), d, v);
      check("post_reset_read", d, 32'h0);
    end
    repeat (2) @(negedge clk_clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
